filtr_sequencer: RTL and testbench
==================================

# filtr_sequencer

Sample-rate controller that sequences `filtr_top`. It accepts input samples over a valid/ready handshake and issues each one to the filter on a programmable sample tick as a single-cycle `sample` strobe. It then waits for `filter_done`, guarded by a timeout, captures `data_out` and presents the result downstream over a valid/ready handshake. It sits between the sample source and the filter core and replaces hand-driven `sample` pulses.

## Interface
- `DATA_SIZE`, 5, sample/result width; must match the filter core.
- `PERIOD_W`, 8, width of the sample-period register.
- `TIMEOUT`, 32, maximum number of WAIT_DONE cycles before abort; must be ≥ 2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `period`  in  PERIOD_W  sample period in clk cycles; 0 is treated as 1.
- `in_valid`  in  1  source has a sample.
- `in_data`  in  DATA_SIZE  source sample.
- `in_ready`  out  1  sequencer can accept a sample.
- `flt_sample`  out  1  one-cycle strobe to the filter `sample` input.
- `flt_data_in`  out  DATA_SIZE  sample to the filter `data_in`; held stable from accept until the next accept.
- `flt_done`  in  1  filter `filter_done`.
- `flt_data_out`  in  DATA_SIZE  filter `data_out`.
- `out_valid`  out  1  result available.
- `out_data`  out  DATA_SIZE  captured filter result.
- `out_ready`  in  1  sink accepts the result.
- `busy`  out  1  state ≠ IDLE.
- `timeout_err`  out  1  sticky flag; set on a filter timeout, cleared only by reset.

## Operation
- Tick generator: free-running counter `cnt` (PERIOD_W bits). `lim = max(period,1) - 1`.
  - `tick = (cnt == lim)`.
  - When `cnt >= lim`, the next `cnt` is 0; otherwise `cnt+1`.
  - Runs in every state.
  - If `period` is reduced below the current `cnt`, the counter wraps to 0 on the next edge with no tick in that cycle.
- FSM (Moore outputs, one-hot or binary encoding):
  - IDLE: `in_ready=1`. On `in_valid`, latch `in_data` into `flt_data_in` and go to WAIT_TICK.
  - WAIT_TICK: on `tick`, go to ISSUE.
  - ISSUE: `flt_sample=1` for exactly this cycle. Clear the timeout counter `tmo`. Always go to WAIT_DONE next.
  - WAIT_DONE: `tmo` increments each cycle.
    - On `flt_done=1`: `out_data <= flt_data_out`, go to OUTPUT.
    - Else, when `tmo == TIMEOUT-1`: set `timeout_err` and go to IDLE. The sample is dropped and `out_data` is unchanged.
    - If `flt_done` is high in the same cycle the timeout is reached, `flt_done` wins.
  - OUTPUT: `out_valid=1`. `out_data` is stable while `out_valid` is high. On `out_ready`, go to IDLE.
- `flt_done` is ignored outside WAIT_DONE, including the ISSUE cycle.
- `in_ready` is 0 in every state except IDLE. Samples offered while busy are back-pressured, never lost.
- Arithmetic: `tmo` width is `$clog2(TIMEOUT)`. No saturation is needed because `tmo` is cleared in ISSUE.

## Timing
- Reset values: state IDLE, `cnt=0`, `tmo=0`, `in_ready=1`, `flt_sample=0`, `flt_data_in=0`, `out_valid=0`, `out_data=0`, `busy=0`, `timeout_err=0`.
- Reset asserted mid-operation aborts immediately, asynchronously. The pending sample and result are discarded. After deassertion, operation resumes from IDLE with `cnt=0`.
- Accept at edge k means WAIT_TICK from k+1. With `period=1`, `flt_sample` is high in cycle k+2.
- General case: `flt_sample` asserts in the cycle after the first tick at or after cycle k+1.
- `flt_done` seen high before edge m means `out_valid` is high from m. Minimum accept-to-`out_valid` is 4 cycles.
- Back-to-back throughput is at most one sample per `max(period,1)` cycles. It is also limited by filter latency and `out_ready`.

## Test plan
- Reset: hold `reset=1` for 3 cycles with random inputs. All outputs equal their reset values; `in_ready=1`.
- Nominal: `period=6`, `in_data=1`, filter model raises `flt_done` 4 cycles after `sample` with `data_out=5`. Expect exactly one 1-cycle `flt_sample` aligned to a tick, `out_valid` with `out_data=5`, and back to IDLE after `out_ready`.
- Back-pressure: keep `in_valid=1` with values 1,2,3 and `out_ready=0` for 10 cycles. Only sample 1 is accepted; `in_ready=0` and `out_data` is stable until `out_ready=1`. Then 2 and 3 are processed in order.
- Timeout: `TIMEOUT=32`, filter never asserts done. Exactly 32 cycles after ISSUE, `timeout_err=1` and the FSM is in IDLE. The next sample completes normally while `timeout_err` stays 1.
- Boundaries:
  - `period=0` behaves like `period=1`.
  - Changing `period` from 200 to 3 while `cnt=150` wraps the counter and ticks 3 cycles later.
  - A `flt_done` pulse during WAIT_TICK is ignored.
  - `flt_done` coinciding with `tmo=31` captures the result and does not set `timeout_err`.
- Reset mid-WAIT_DONE: assert `reset` for 1 cycle. `flt_sample`, `out_valid` and `busy` drop immediately, and a stale `flt_done` arriving afterward produces no output.

Source files
------------

// File: rtl/filtr_sequencer.sv
// Sample-rate sequencer for filtr_top: accepts samples over valid/ready, issues
// them on a programmable tick, waits for the filter under a timeout, returns results.
module filtr_sequencer #(
  parameter int DATA_SIZE = 5,
  parameter int PERIOD_W  = 8,
  parameter int TIMEOUT   = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [PERIOD_W-1:0]  period_i,
  input  logic                 in_valid_i,
  input  logic [DATA_SIZE-1:0] in_data_i,
  output logic                 in_ready_o,
  output logic                 flt_sample_o,
  output logic [DATA_SIZE-1:0] flt_data_in_o,
  input  logic                 flt_done_i,
  input  logic [DATA_SIZE-1:0] flt_data_out_i,
  output logic                 out_valid_o,
  output logic [DATA_SIZE-1:0] out_data_o,
  input  logic                 out_ready_i,
  output logic                 busy_o,
  output logic                 timeout_err_o
);

  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    ISSUE,
    WAIT_DONE,
    OUTPUT
  } state_e;

  state_e               state_q, state_d;
  logic [PERIOD_W-1:0]  cnt_q, cnt_d, lim;
  logic                 tick;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [DATA_SIZE-1:0] fltData_q, fltData_d;
  logic [DATA_SIZE-1:0] outData_q, outData_d;
  logic                 timeoutErr_q, timeoutErr_d;

  // A period of 0 behaves like 1; the >= compare wraps the counter at once
  // when the period is shrunk below its current value.
  always_comb begin
    lim   = (period_i == '0) ? '0 : period_i - PERIOD_W'(1);
    tick  = (cnt_q == lim);
    cnt_d = (cnt_q >= lim) ? '0 : cnt_q + PERIOD_W'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tmo_q        <= '0;
      fltData_q    <= '0;
      outData_q    <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      fltData_q    <= fltData_d;
      outData_q    <= outData_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    fltData_d    = fltData_q;
    outData_d    = outData_q;
    timeoutErr_d = timeoutErr_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          fltData_d = in_data_i;
          state_d   = WAIT_TICK;
        end
      end
      WAIT_TICK: begin
        if (tick) state_d = ISSUE;
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT_DONE;
      end
      // A done arriving on the last allowed cycle still wins over the timeout.
      WAIT_DONE: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (flt_done_i) begin
          outData_d = flt_data_out_i;
          state_d   = OUTPUT;
        end else if (tmo_q == TMO_LAST) begin
          timeoutErr_d = 1'b1;
          state_d      = IDLE;
        end
      end
      OUTPUT: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready_o    = (state_q == IDLE);
  assign flt_sample_o  = (state_q == ISSUE);
  assign flt_data_in_o = fltData_q;
  assign out_valid_o   = (state_q == OUTPUT);
  assign out_data_o    = outData_q;
  assign busy_o        = (state_q != IDLE);
  assign timeout_err_o = timeoutErr_q;

endmodule

// File: tb/tb_filtr_sequencer.sv
// Bench for filtr_sequencer: behavioural filter + cycle-timeline model, with a
// result scoreboard fed at issue time and drained by an output monitor.
module tb_filtr_sequencer;

  localparam int DW  = 5;
  localparam int PW  = 8;
  localparam int TMO = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] period;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          flt_sample;
  logic [DW-1:0] flt_data_in;
  logic          flt_done = 1'b0;
  logic [DW-1:0] flt_data_out = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          timeout_err;

  always #5 clk = ~clk;

  filtr_sequencer #(.DATA_SIZE(DW), .PERIOD_W(PW), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .reset_i(reset), .period_i(period),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .flt_sample_o(flt_sample), .flt_data_in_o(flt_data_in),
    .flt_done_i(flt_done), .flt_data_out_i(flt_data_out),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
    .busy_o(busy), .timeout_err_o(timeout_err)
  );

  typedef struct {
    bit            isTimeout;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          expQ[$];
  logic [DW-1:0] acceptQ[$];
  int vectors = 0, miscompares = 0, cyc = 0, dutAccepts = 0;

  // Timeline model of the sequencer as seen from its ports.
  int  mcnt = 0, doneAt = -1, timeoutAt = -1, pendUntil = -1;
  bit  eBusy = 0, eOutValid = 0, eSample = 0, eTerr = 0, waitTick = 0;
  bit  nextDone = 0;
  logic [DW-1:0] nextDout = '0, resultVal = '0;

  int latMode = 3, orMode = 1;
  bit strayEn = 0, forceDone = 0;
  int s, t, c, n;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic failNote(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic logic [DW-1:0] filterFn(input logic [DW-1:0] x);
    return DW'((x * 3 + 2) % 32);
  endfunction

  // Latency from sample strobe to done; anything above TMO means the filter never answers.
  function automatic int pickLatency();
    int r;
    case (latMode)
      1: return 99;
      2: return TMO;
      3: return 4;
      default: begin
        r = $urandom_range(0, 9);
        if (r < 7) return $urandom_range(1, 6);
        if (r == 7) return TMO;
        if (r == 8) return TMO - 1;
        return 99;
      end
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    flt_done     = nextDone;
    flt_data_out = nextDout;
    case (orMode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Reference model and filter: checks this cycle, then advances one cycle.
  always @(negedge clk) begin
    int lim, d;
    bit tick, acc, hs, nBusy, nOv, nTerr, nSample;
    logic [DW-1:0] x;
    exp_t e;
    if (reset) begin
      mcnt = 0; eBusy = 0; eOutValid = 0; eSample = 0; eTerr = 0; waitTick = 0;
      doneAt = -1; timeoutAt = -1; pendUntil = -1; nextDone = 0; nextDout = '0;
      acceptQ.delete();
      expQ.delete();
    end else begin
      checkOutput("in_ready", 32'(in_ready), 32'(!eBusy));
      checkOutput("busy", 32'(busy), 32'(eBusy));
      checkOutput("out_valid", 32'(out_valid), 32'(eOutValid));
      checkOutput("timeout_err", 32'(timeout_err), 32'(eTerr));
      if (eSample || flt_sample) checkOutput("flt_sample", 32'(flt_sample), 32'(eSample));
      lim   = (period == 0) ? 0 : int'(period) - 1;
      tick  = (mcnt == lim);
      acc   = in_valid && !eBusy;
      hs    = eOutValid && out_ready;
      nBusy = eBusy; nOv = eOutValid; nTerr = eTerr; nSample = 0;
      if (eSample) begin
        x = '0;
        if (acceptQ.size() == 0) failNote("issue_without_accept");
        else x = acceptQ.pop_front();
        checkOutput("flt_data_in", 32'(flt_data_in), 32'(x));
        d = pickLatency();
        pendUntil = cyc + TMO + 1;
        if (d <= TMO) begin
          doneAt    = cyc + d;
          timeoutAt = -1;
          resultVal = filterFn(x);
          e.isTimeout = 0;
          e.data      = resultVal;
        end else begin
          doneAt    = -1;
          timeoutAt = cyc + TMO + 1;
          e.isTimeout = 1;
          e.data      = '0;
        end
        expQ.push_back(e);
      end
      if (waitTick && tick) begin
        nSample  = 1;
        waitTick = 0;
      end
      if (acc) begin
        acceptQ.push_back(in_data);
        waitTick = 1;
        nBusy    = 1;
      end
      if (cyc == doneAt) nOv = 1;
      if (hs) begin
        nOv   = 0;
        nBusy = 0;
      end
      if (cyc + 1 == timeoutAt) begin
        nBusy = 0;
        nTerr = 1;
      end
      eBusy = nBusy; eOutValid = nOv; eTerr = nTerr; eSample = nSample;
      mcnt = (mcnt >= lim) ? 0 : mcnt + 1;
      nextDone = (cyc + 1 == doneAt) || forceDone ||
                 (strayEn && (cyc + 1 > pendUntil) && ($urandom_range(0, 5) == 0));
      nextDout = (cyc + 1 == doneAt) ? resultVal : DW'($urandom);
    end
  end

  // Output monitor: drains the scoreboard on result handshakes and on dropped samples.
  bit prevBusy = 0, prevHs = 0, prevOv = 0;
  logic [DW-1:0] prevOut = '0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prevBusy = 0; prevHs = 0; prevOv = 0;
    end else begin
      if (in_valid && in_ready) dutAccepts++;
      if (prevOv && !prevHs && out_valid) checkOutput("out_data_stable", 32'(out_data), 32'(prevOut));
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) failNote("unexpected_result");
        else begin
          e = expQ.pop_front();
          checkOutput("result_not_dropped", 32'(0), 32'(e.isTimeout));
          checkOutput("out_data", 32'(out_data), 32'(e.data));
        end
      end
      if (prevBusy && !busy && !prevHs) begin
        if (expQ.size() == 0) failNote("unexpected_drop");
        else begin
          e = expQ.pop_front();
          checkOutput("drop_was_timeout", 32'(1), 32'(e.isTimeout));
          checkOutput("drop_sets_timeout_err", 32'(timeout_err), 32'(1));
        end
      end
      prevBusy = busy;
      prevHs   = out_valid && out_ready;
      prevOv   = out_valid;
      prevOut  = out_data;
    end
  end

  task automatic applyStimulus(input logic [DW-1:0] d);
    int start;
    int k;
    start = dutAccepts;
    k = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (dutAccepts == start && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    if (dutAccepts == start) failNote("accept_timeout");
  endtask

  task automatic waitSample(output int sc);
    int k;
    k = 0;
    sc = -1;
    while (!flt_sample && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    if (flt_sample) sc = cyc;
    else failNote("sample_wait");
  endtask

  task automatic waitIdle(output int ic);
    int k;
    k = 0;
    while ((busy || out_valid) && k < 600) begin
      @(posedge clk); #1;
      k++;
    end
    ic = cyc;
    if (busy || out_valid) failNote("idle_wait");
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_data = 5'd9; period = 8'd6; orMode = 2;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("rst_in_ready", 32'(in_ready), 32'(1));
      checkOutput("rst_flt_sample", 32'(flt_sample), 32'(0));
      checkOutput("rst_flt_data_in", 32'(flt_data_in), 32'(0));
      checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
      checkOutput("rst_out_data", 32'(out_data), 32'(0));
      checkOutput("rst_busy", 32'(busy), 32'(0));
      checkOutput("rst_timeout_err", 32'(timeout_err), 32'(0));
      in_valid = 1'($urandom_range(0, 1));
      in_data  = DW'($urandom);
      period   = PW'($urandom);
    end
    in_valid = 1'b0; period = 8'd6; orMode = 1;
    reset = 1'b0;

    // Nominal transaction: filter answers 5 four cycles after the strobe.
    latMode = 3;
    applyStimulus(5'd1);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    checkOutput("nominal_out_data", 32'(out_data), 32'(5));
    waitIdle(t);

    // Back-pressure: three offers in a row with the sink stalled.
    orMode = 0;
    c = dutAccepts;
    fork
      begin
        applyStimulus(5'd1);
        applyStimulus(5'd2);
        applyStimulus(5'd3);
        in_valid = 1'b0;
      end
      begin
        repeat (30) @(posedge clk);
        #1;
        checkOutput("bp_accept_count", 32'(dutAccepts - c), 32'(1));
        checkOutput("bp_in_ready", 32'(in_ready), 32'(0));
        checkOutput("bp_out_valid", 32'(out_valid), 32'(1));
        checkOutput("bp_out_data", 32'(out_data), 32'(filterFn(5'd1)));
        orMode = 1;
      end
    join
    waitIdle(t);

    // Filter never answers: 32 WAIT_DONE cycles, then a sticky error.
    period = 8'd3; latMode = 1;
    applyStimulus(5'd7);
    in_valid = 1'b0;
    waitSample(s);
    waitIdle(t);
    checkOutput("tmo_wait_cycles", 32'(t - s - 1), 32'(TMO));
    checkOutput("tmo_err_set", 32'(timeout_err), 32'(1));
    latMode = 3;
    applyStimulus(5'd9);
    in_valid = 1'b0;
    waitIdle(t);
    checkOutput("tmo_err_sticky", 32'(timeout_err), 32'(1));

    // Period 0 acts as 1: strobe two cycles after the accept edge.
    period = 8'd0;
    applyStimulus(5'd4);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("period0_issue", 32'(flt_sample), 32'(1));
    waitIdle(t);

    // Shrink period 200 -> 3 at cnt=150, with stray done pulses in WAIT_TICK.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; period = 8'd200; strayEn = 1; latMode = 3;
    applyStimulus(5'd12);
    in_valid = 1'b0;
    n = 0;
    while (mcnt != 150 && n < 300) begin @(posedge clk); #1; n++; end
    period = 8'd3;
    c = cyc;
    waitSample(s);
    checkOutput("period_shrink_issue", 32'(s - c), 32'(4));
    waitIdle(t);

    // Done on the very last WAIT_DONE cycle wins over the timeout.
    strayEn = 0; latMode = 2; period = 8'd1;
    applyStimulus(5'd20);
    in_valid = 1'b0;
    waitIdle(t);
    checkOutput("tmo31_no_err", 32'(timeout_err), 32'(0));

    // Reset in WAIT_DONE, followed by a stale done from the filter.
    latMode = 1;
    applyStimulus(5'd13);
    in_valid = 1'b0;
    waitSample(s);
    repeat (5) begin @(posedge clk); #1; end
    checkOutput("pre_rst_busy", 32'(busy), 32'(1));
    reset = 1'b1;
    #1;
    checkOutput("async_rst_busy", 32'(busy), 32'(0));
    checkOutput("async_rst_flt_sample", 32'(flt_sample), 32'(0));
    checkOutput("async_rst_out_valid", 32'(out_valid), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    forceDone = 1;
    @(posedge clk); #1;
    forceDone = 0;
    repeat (6) begin
      @(posedge clk); #1;
      checkOutput("stale_done_out_valid", 32'(out_valid), 32'(0));
    end

    // Randomized traffic.
    strayEn = 1; orMode = 2; latMode = 0;
    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = $urandom_range(0, 4);
      period = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd1 : (sel == 2) ? 8'd2 : (sel == 3) ? 8'd5 : 8'd9;
      applyStimulus(DW'($urandom));
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        in_data = DW'($urandom);
      end
    end
    orMode = 1;
    waitIdle(t);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
